// File: rtl/ariane_pkg.sv
// ============================================================================
//  Module      : ariane_pkg
//  Description : Shared core types consumed by the execute-side dispatch logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_pkg;

    localparam int unsigned VLEN          = 64;
    localparam bit          FP_PRESENT    = 1'b1;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR,
        FPU,
        FPU_VEC
    } fu_t;

    typedef struct packed {
        logic [7:0]               operation;
        logic [63:0]              operand_a;
        logic [63:0]              operand_b;
        logic [63:0]              imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    typedef struct packed {
        logic            valid;
        logic            predict_taken;
        logic [VLEN-1:0] predict_address;
    } branchpredict_sbe_t;

endpackage

`default_nettype wire

// File: rtl/fu_dispatch_pkg.sv
// ============================================================================
//  Module      : fu_dispatch_pkg
//  Description : Unit-select encoding shared by the dispatch top and its decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fu_dispatch_pkg;

    typedef struct packed {
        logic alu;
        logic branch;
        logic csr;
        logic mult;
        logic lsu;
        logic fpu;
        logic unsupported;
    } unit_sel_t;

    // Units that write back through the shared fixed-latency port in the
    // same cycle they fire, and therefore collide with a multiplier result.
    function automatic logic uses_flu_port(input unit_sel_t sel);
        return sel.alu | sel.branch | sel.csr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fu_dispatch_sel.sv
// ============================================================================
//  Module      : fu_dispatch_sel
//  Description : Maps a functional-unit class to a one-hot unit select and
//                whether that unit can accept an instruction this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_dispatch_sel
    import ariane_pkg::*;
    import fu_dispatch_pkg::*;
#(
    parameter bit FpPresent = FP_PRESENT
) (
    input  fu_t       i_fu,
    input  logic      i_flu_ready,
    input  logic      i_lsu_ready,
    input  logic      i_fpu_ready,
    output unit_sel_t o_unit,
    output logic      o_ready
);

    always_comb begin
        o_unit  = '0;
        o_ready = 1'b0;
        case (i_fu)
            LOAD, STORE: begin
                o_unit.lsu = 1'b1;
                o_ready    = i_lsu_ready;
            end
            ALU: begin
                o_unit.alu = 1'b1;
                o_ready    = i_flu_ready;
            end
            CTRL_FLOW: begin
                o_unit.branch = 1'b1;
                o_ready       = i_flu_ready;
            end
            MULT: begin
                o_unit.mult = 1'b1;
                o_ready     = i_flu_ready;
            end
            CSR: begin
                o_unit.csr = 1'b1;
                o_ready    = i_flu_ready;
            end
            FPU, FPU_VEC: begin
                // Without an FPU the op is retired immediately and flagged.
                if (FpPresent) begin
                    o_unit.fpu = 1'b1;
                    o_ready    = i_fpu_ready;
                end else begin
                    o_unit.unsupported = 1'b1;
                    o_ready            = 1'b1;
                end
            end
            default: begin
                o_ready = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fu_dispatch.sv
// ============================================================================
//  Module      : fu_dispatch
//  Description : Single-entry dispatch register firing one-cycle valid pulses
//                to the execute-stage functional units.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_dispatch
    import ariane_pkg::*;
    import fu_dispatch_pkg::*;
#(
    parameter bit          FpPresent     = FP_PRESENT,
    parameter int unsigned StallCntWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  fu_t                      issue_fu_i,
    input  fu_data_t                 issue_data_i,
    input  logic [VLEN-1:0]          issue_pc_i,
    input  logic                     issue_is_compressed_i,
    input  branchpredict_sbe_t       issue_bp_i,
    input  logic                     flu_ready_i,
    input  logic                     lsu_ready_i,
    input  logic                     fpu_ready_i,
    output fu_data_t                 fu_data_o,
    output logic [VLEN-1:0]          pc_o,
    output logic                     is_compressed_instr_o,
    output branchpredict_sbe_t       branch_predict_o,
    output logic                     alu_valid_o,
    output logic                     branch_valid_o,
    output logic                     csr_valid_o,
    output logic                     mult_valid_o,
    output logic                     lsu_valid_o,
    output logic                     fpu_valid_o,
    output logic                     unsupported_o,
    output logic [StallCntWidth-1:0] stall_cnt_o
);

    logic                     r_valid;
    logic                     r_mult_shadow;
    fu_t                      r_fu;
    fu_data_t                 r_data;
    logic [VLEN-1:0]          r_pc;
    logic                     r_is_compressed;
    branchpredict_sbe_t       r_bp;
    logic [StallCntWidth-1:0] r_stall_cnt;

    unit_sel_t w_unit;
    logic      w_unit_ready;
    logic      w_hazard;
    logic      w_fire;
    logic      w_capture;

    fu_dispatch_sel #(
        .FpPresent (FpPresent)
    ) u_sel (
        .i_fu        (r_fu),
        .i_flu_ready (flu_ready_i),
        .i_lsu_ready (lsu_ready_i),
        .i_fpu_ready (fpu_ready_i),
        .o_unit      (w_unit),
        .o_ready     (w_unit_ready)
    );

    // A multiply fired last cycle owns the shared writeback port this cycle.
    assign w_hazard  = r_mult_shadow & uses_flu_port(w_unit);
    assign w_fire    = r_valid & w_unit_ready & ~w_hazard & ~flush_i;
    assign w_capture = issue_valid_i & issue_ready_o & ~flush_i;

    assign issue_ready_o = flush_i | ~r_valid | w_fire;

    assign alu_valid_o    = w_fire & w_unit.alu;
    assign branch_valid_o = w_fire & w_unit.branch;
    assign csr_valid_o    = w_fire & w_unit.csr;
    assign mult_valid_o   = w_fire & w_unit.mult;
    assign lsu_valid_o    = w_fire & w_unit.lsu;
    assign fpu_valid_o    = w_fire & w_unit.fpu;
    assign unsupported_o  = w_fire & w_unit.unsupported;

    assign fu_data_o             = r_data;
    assign pc_o                  = r_pc;
    assign is_compressed_instr_o = r_is_compressed;
    assign branch_predict_o      = r_bp;
    assign stall_cnt_o           = r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid       <= 1'b0;
            r_mult_shadow <= 1'b0;
        end else if (flush_i) begin
            r_valid       <= 1'b0;
            r_mult_shadow <= 1'b0;
        end else begin
            if (w_capture) begin
                r_valid <= 1'b1;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            r_mult_shadow <= w_fire & w_unit.mult;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fu            <= NONE;
            r_data          <= '0;
            r_pc            <= '0;
            r_is_compressed <= 1'b0;
            r_bp            <= '0;
        end else if (w_capture) begin
            r_fu            <= issue_fu_i;
            r_data          <= issue_data_i;
            r_pc            <= issue_pc_i;
            r_is_compressed <= issue_is_compressed_i;
            r_bp            <= issue_bp_i;
        end
    end

    // Saturating: a wrapped count would hide a pathological stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !w_fire && !flush_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + {{(StallCntWidth-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fu_dispatch.sv
// ============================================================================
//  Module      : tb_fu_dispatch
//  Description : Directed self-checking bench for fu_dispatch (FPU present and
//                absent builds driven side by side).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fu_dispatch;
    import ariane_pkg::*;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic               flush;
    logic               issue_valid;
    fu_t                issue_fu;
    fu_data_t           issue_data;
    logic [VLEN-1:0]    issue_pc;
    logic               issue_c;
    branchpredict_sbe_t issue_bp;
    logic               flu_ready, lsu_ready, fpu_ready;

    logic               ready;
    fu_data_t           fu_data;
    logic [VLEN-1:0]    pc;
    logic               isc;
    branchpredict_sbe_t bp;
    logic               alu_v, br_v, csr_v, mult_v, lsu_v, fpu_v, unsup;
    logic [31:0]        stall;

    logic               ready_n;
    fu_data_t           fu_data_n;
    logic [VLEN-1:0]    pc_n;
    logic               isc_n;
    branchpredict_sbe_t bp_n;
    logic               alu_vn, br_vn, csr_vn, mult_vn, lsu_vn, fpu_vn, unsup_n;
    logic [2:0]         stall_n;

    logic [6:0] vals, vals_n;
    assign vals   = {alu_v, br_v, csr_v, mult_v, lsu_v, fpu_v, unsup};
    assign vals_n = {alu_vn, br_vn, csr_vn, mult_vn, lsu_vn, fpu_vn, unsup_n};

    localparam logic [6:0] V_NONE = 7'b0000000;
    localparam logic [6:0] V_ALU  = 7'b1000000;
    localparam logic [6:0] V_CSR  = 7'b0010000;
    localparam logic [6:0] V_MULT = 7'b0001000;
    localparam logic [6:0] V_LSU  = 7'b0000100;
    localparam logic [6:0] V_FPU  = 7'b0000010;
    localparam logic [6:0] V_UNS  = 7'b0000001;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fu_dispatch #(.FpPresent(1'b1), .StallCntWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_ready_o(ready),
        .issue_fu_i(issue_fu), .issue_data_i(issue_data), .issue_pc_i(issue_pc),
        .issue_is_compressed_i(issue_c), .issue_bp_i(issue_bp),
        .flu_ready_i(flu_ready), .lsu_ready_i(lsu_ready), .fpu_ready_i(fpu_ready),
        .fu_data_o(fu_data), .pc_o(pc), .is_compressed_instr_o(isc),
        .branch_predict_o(bp),
        .alu_valid_o(alu_v), .branch_valid_o(br_v), .csr_valid_o(csr_v),
        .mult_valid_o(mult_v), .lsu_valid_o(lsu_v), .fpu_valid_o(fpu_v),
        .unsupported_o(unsup), .stall_cnt_o(stall)
    );

    fu_dispatch #(.FpPresent(1'b0), .StallCntWidth(3)) dut_nofp (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_ready_o(ready_n),
        .issue_fu_i(issue_fu), .issue_data_i(issue_data), .issue_pc_i(issue_pc),
        .issue_is_compressed_i(issue_c), .issue_bp_i(issue_bp),
        .flu_ready_i(flu_ready), .lsu_ready_i(lsu_ready), .fpu_ready_i(fpu_ready),
        .fu_data_o(fu_data_n), .pc_o(pc_n), .is_compressed_instr_o(isc_n),
        .branch_predict_o(bp_n),
        .alu_valid_o(alu_vn), .branch_valid_o(br_vn), .csr_valid_o(csr_vn),
        .mult_valid_o(mult_vn), .lsu_valid_o(lsu_vn), .fpu_valid_o(fpu_vn),
        .unsupported_o(unsup_n), .stall_cnt_o(stall_n)
    );

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled one step later, well before the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_fu    = NONE;
        issue_data  = '0;
        issue_pc    = '0;
        issue_c     = 1'b0;
        issue_bp    = '0;
        flu_ready   = 1'b1;
        lsu_ready   = 1'b1;
        fpu_ready   = 1'b1;
    endtask

    task automatic offer(input fu_t fu, input logic [2:0] tid, input logic [VLEN-1:0] addr);
        issue_valid         = 1'b1;
        issue_fu            = fu;
        issue_data          = '0;
        issue_data.trans_id = tid;
        issue_data.operand_a = 64'hA5A5_0000_0000_0001;
        issue_pc            = addr;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #2;
        checks++; if (vals !== V_NONE) begin errors++; $display("FAIL reset_valids got=%b exp=%b", vals, V_NONE); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (fu_data !== '0) begin errors++; $display("FAIL reset_fu_data got=%h exp=0", fu_data); end
        checks++; if (pc !== '0 || isc !== 1'b0 || bp !== '0) begin errors++; $display("FAIL reset_pc_bp pc=%h isc=%b bp=%h exp=0", pc, isc, bp); end
        checks++; if (stall !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        do_reset();
        offer(ALU, 3'd3, 64'h1000);
        issue_c = 1'b1;
        settle();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL alu_ready_c0 got=%b exp=1", ready); end
        tick();
        idle_inputs();
        settle();
        checks++; if (vals !== V_ALU) begin errors++; $display("FAIL alu_fire got=%b exp=%b", vals, V_ALU); end
        checks++; if (fu_data.trans_id !== 3'd3) begin errors++; $display("FAIL alu_trans_id got=%0d exp=3", fu_data.trans_id); end
        checks++; if (pc !== 64'h1000 || isc !== 1'b1) begin errors++; $display("FAIL alu_pc got=%h/%b exp=1000/1", pc, isc); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL alu_ready_c1 got=%b exp=1", ready); end
        tick();
        settle();
        checks++; if (vals !== V_NONE) begin errors++; $display("FAIL alu_single_pulse got=%b exp=%b", vals, V_NONE); end
    endtask

    task automatic test_mult_shadow();
        do_reset();
        offer(MULT, 3'd1, 64'h2000);
        tick();
        offer(ALU, 3'd2, 64'h2004);
        settle();
        checks++; if (vals !== V_MULT) begin errors++; $display("FAIL shadow_mult_fire got=%b exp=%b", vals, V_MULT); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL shadow_ready_c1 got=%b exp=1", ready); end
        tick();
        idle_inputs();
        settle();
        checks++; if (vals !== V_NONE) begin errors++; $display("FAIL shadow_alu_blocked got=%b exp=%b", vals, V_NONE); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL shadow_ready_c2 got=%b exp=0", ready); end
        tick();
        settle();
        checks++; if (vals !== V_ALU) begin errors++; $display("FAIL shadow_alu_fire got=%b exp=%b", vals, V_ALU); end
        checks++; if (stall !== 32'd1) begin errors++; $display("FAIL shadow_stall got=%0d exp=1", stall); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        offer(MULT, 3'd4, 64'h3000);
        tick();
        offer(MULT, 3'd5, 64'h3004);
        settle();
        checks++; if (vals !== V_MULT || fu_data.trans_id !== 3'd4) begin errors++; $display("FAIL b2b_first got=%b/%0d exp=%b/4", vals, fu_data.trans_id, V_MULT); end
        tick();
        idle_inputs();
        settle();
        checks++; if (vals !== V_MULT || fu_data.trans_id !== 3'd5) begin errors++; $display("FAIL b2b_second got=%b/%0d exp=%b/5", vals, fu_data.trans_id, V_MULT); end
        tick();
        settle();
        checks++; if (vals !== V_NONE) begin errors++; $display("FAIL b2b_idle got=%b exp=%b", vals, V_NONE); end
        checks++; if (stall !== 32'd0) begin errors++; $display("FAIL b2b_stall got=%0d exp=0", stall); end
    endtask

    task automatic test_csr_stall();
        do_reset();
        flu_ready = 1'b0;
        offer(CSR, 3'd6, 64'h4000);
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (vals !== V_NONE || ready !== 1'b0) begin errors++; $display("FAIL csr_hold%0d vals=%b ready=%b exp=%b/0", i, vals, ready, V_NONE); end
            tick();
        end
        flu_ready = 1'b1;
        settle();
        checks++; if (vals !== V_CSR) begin errors++; $display("FAIL csr_fire got=%b exp=%b", vals, V_CSR); end
        checks++; if (stall !== 32'd5) begin errors++; $display("FAIL csr_stall got=%0d exp=5", stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        lsu_ready = 1'b0;
        offer(LOAD, 3'd2, 64'h5000);
        tick();
        issue_valid = 1'b0;
        settle();
        checks++; if (vals !== V_NONE || ready !== 1'b0) begin errors++; $display("FAIL flush_hold vals=%b ready=%b exp=%b/0", vals, ready, V_NONE); end
        tick();
        flush     = 1'b1;
        lsu_ready = 1'b1;
        offer(ALU, 3'd7, 64'h5004);
        settle();
        checks++; if (vals !== V_NONE || ready !== 1'b1) begin errors++; $display("FAIL flush_cycle vals=%b ready=%b exp=%b/1", vals, ready, V_NONE); end
        tick();
        idle_inputs();
        settle();
        checks++; if (vals !== V_NONE || ready !== 1'b1) begin errors++; $display("FAIL flush_after vals=%b ready=%b exp=%b/1", vals, ready, V_NONE); end
        checks++; if (stall !== 32'd1) begin errors++; $display("FAIL flush_stall got=%0d exp=1", stall); end
        offer(ALU, 3'd6, 64'h5008);
        tick();
        idle_inputs();
        settle();
        checks++; if (vals !== V_ALU || fu_data.trans_id !== 3'd6) begin errors++; $display("FAIL flush_next got=%b/%0d exp=%b/6", vals, fu_data.trans_id, V_ALU); end
    endtask

    task automatic test_fpu_absent();
        do_reset();
        fpu_ready = 1'b0;
        offer(FPU, 3'd1, 64'h6000);
        tick();
        issue_valid = 1'b0;
        settle();
        checks++; if (vals_n !== V_UNS) begin errors++; $display("FAIL nofp_unsupported got=%b exp=%b", vals_n, V_UNS); end
        checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL nofp_ready got=%b exp=1", ready_n); end
        checks++; if (vals !== V_NONE) begin errors++; $display("FAIL fp_wait got=%b exp=%b", vals, V_NONE); end
        tick();
        fpu_ready = 1'b1;
        settle();
        checks++; if (vals_n !== V_NONE) begin errors++; $display("FAIL nofp_freed got=%b exp=%b", vals_n, V_NONE); end
        checks++; if (vals !== V_FPU) begin errors++; $display("FAIL fp_fire got=%b exp=%b", vals, V_FPU); end
        tick();
        idle_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        lsu_ready = 1'b0;
        offer(STORE, 3'd3, 64'h7000);
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (stall_n !== 3'd7) begin errors++; $display("FAIL stall_saturate got=%0d exp=7", stall_n); end
        checks++; if (stall !== 32'd10) begin errors++; $display("FAIL stall_count got=%0d exp=10", stall); end
        lsu_ready = 1'b1;
        settle();
        checks++; if (vals !== V_LSU) begin errors++; $display("FAIL store_fire got=%b exp=%b", vals, V_LSU); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        lsu_ready = 1'b0;
        offer(LOAD, 3'd5, 64'h8000);
        tick();
        issue_valid = 1'b0;
        rst_ni      = 1'b0;
        lsu_ready   = 1'b1;
        settle();
        checks++; if (vals !== V_NONE || ready !== 1'b1) begin errors++; $display("FAIL rstmid_async vals=%b ready=%b exp=%b/1", vals, ready, V_NONE); end
        tick();
        rst_ni = 1'b1;
        tick();
        settle();
        checks++; if (vals !== V_NONE || fu_data !== '0) begin errors++; $display("FAIL rstmid_discard vals=%b data=%h exp=%b/0", vals, fu_data, V_NONE); end
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b1;
        #3;
        test_reset();
        test_alu();
        test_mult_shadow();
        test_back_to_back();
        test_csr_stall();
        test_flush();
        test_fpu_absent();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fu_dispatch.md
Name: fu_dispatch

Overview:
Issue-side initiator for the execute stage. It accepts one decoded instruction per cycle from the issue stage and holds it in a single-entry dispatch register. It fires the instruction as a one-cycle valid pulse to exactly one functional unit (ALU, branch, CSR, MULT, LSU, FPU) once that unit is ready and no writeback-port collision can occur. It drives the fu_data/pc/branch-predict bundle that the execute stage consumes.

Parameters:
FpPresent, 1, FPU exists; if 0, FPU-class ops are dropped and flagged.
StallCntWidth, 32, width of the saturating stall-cycle counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  pipeline flush
issue_valid_i  in  1  issue stage offers an instruction
issue_ready_o  out  1  dispatch entry can accept this cycle
issue_fu_i  in  fu_t  target unit class
issue_data_i  in  fu_data_t  operands, op, trans_id
issue_pc_i  in  VLEN  instruction PC
issue_is_compressed_i  in  1  compressed-instruction flag
issue_bp_i  in  branchpredict_sbe_t  prediction info
flu_ready_i  in  1  shared fixed-latency port ready (CSR buffer free, no divide running)
lsu_ready_i  in  1  LSU ready
fpu_ready_i  in  1  FPU ready
fu_data_o  out  fu_data_t  registered operand bundle
pc_o  out  VLEN  registered PC
is_compressed_instr_o  out  1  registered compressed flag
branch_predict_o  out  branchpredict_sbe_t  registered prediction
alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o, lsu_valid_o, fpu_valid_o  out  1 each  one-cycle fire pulses
unsupported_o  out  1  pulse: FPU op dropped because FpPresent=0
stall_cnt_o  out  StallCntWidth  cycles an entry was held without firing

Behaviour:
- Reset (async, rst_ni low): valid_q=0, mult_shadow_q=0, stall_cnt=0. All *_valid_o=0 and unsupported_o=0. Data outputs are 0. issue_ready_o=1.
- Capture: when issue_valid_i && issue_ready_o && !flush_i, latch the fu/data/pc/compressed/bp bundle and set valid_q=1. Data outputs reflect the latched bundle. Minimum latency issue→fire is 1 cycle.
- Unit mapping:
  - LOAD/STORE → lsu.
  - ALU → alu.
  - CTRL_FLOW → branch.
  - MULT → mult.
  - CSR → csr.
  - FPU/FPU_VEC → fpu.
  - NONE → fires with no unit valid.
- Unit readiness:
  - alu/branch/csr/mult need flu_ready_i.
  - lsu needs lsu_ready_i.
  - fpu needs fpu_ready_i (if FpPresent=1).
  - NONE is always ready.
  - FPU with FpPresent=0 is always ready and pulses unsupported_o instead of fpu_valid_o.
- Collision hazard: the multiplier writes the shared FLU port one cycle after it fires.
  - mult_shadow_q is set for exactly the cycle after a MULT fire.
  - While mult_shadow_q=1, alu/branch/csr are blocked.
  - MULT is not blocked (back-to-back multiplies pipeline); lsu, fpu and NONE are not blocked.
- fire = valid_q && unit_ready && !hazard && !flush_i. The target *_valid_o equals fire, combinational from state and ready inputs. At most one valid is high per cycle.
- issue_ready_o = !valid_q || fire. A new instruction can be captured in the same cycle the held one fires.
- Fire without a same-cycle capture clears valid_q.
- flush_i (dominates everything):
  - No valid fires that cycle.
  - valid_q and mult_shadow_q clear next cycle.
  - An issue offered in the same cycle is dropped; issue_ready_o stays 1.
- stall_cnt: +1 on each cycle with valid_q && !fire && !flush_i. It saturates at all-ones and is cleared only by reset.
- Reset mid-operation: the held entry is discarded and no pulse is produced.

Decomposition:
- fu_t, fu_data_t, branchpredict_sbe_t, VLEN and FP_PRESENT already live in ariane_pkg. Add nothing new there.
- The unit-select/readiness decode is a natural combinational sub-module, fu_dispatch_sel, which maps fu_t and the ready inputs to {unit one-hot, ready}.
- The register, shadow and counter logic stay in fu_dispatch.

Test Plan:
- ALU op, trans_id=3, all ready, issue at cycle 0 → alu_valid_o=1 at cycle 1 with fu_data_o.trans_id=3; issue_ready_o=1 throughout.
- MULT at cycle 0, ALU at cycle 1 → mult_valid_o at cycle 1; alu_valid_o=0 at cycle 2 (shadow); alu_valid_o=1 at cycle 3; stall_cnt_o=1.
- MULT, MULT back-to-back → mult_valid_o high at cycles 1 and 2, no stall, stall_cnt_o=0.
- CSR with flu_ready_i=0 for 5 cycles → csr_valid_o=0 and issue_ready_o=0 during the hold; csr_valid_o=1 on the first ready cycle; stall_cnt_o=5.
- LOAD held with lsu_ready_i=0, flush_i pulsed → no lsu_valid_o ever; valid_q cleared; next issue accepted.
- FpPresent=0, FPU op → unsupported_o=1 for one cycle, fpu_valid_o=0, entry freed.
